// File: rtl/ddr4_host_cmd_seq.sv
// Host-side DDR4 command sequencer: turns one read/write request at a time into a
// closed-page ACT -> RD/WR -> PRE sequence, drives write bursts and captures read bursts.
// Command states (IDLE, ACT, CMD, PRE) are "pending": the command goes out on the next
// edge when stall is low, otherwise the FSM waits there driving DES.
module ddr4_host_cmd_seq #(
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned DQWIDTH   = 64,
  parameter int unsigned BL        = 8,
  parameter int unsigned TRCD      = 4,
  parameter int unsigned TCL       = 6,
  parameter int unsigned TCWL      = 5,
  parameter int unsigned TWR       = 4,
  parameter int unsigned TRP       = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [BGWIDTH-1:0]      req_bg,
  input  logic [BAWIDTH-1:0]      req_ba,
  input  logic [ADDRWIDTH-1:0]    req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic [BL*DQWIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [BL*DQWIDTH-1:0]   rsp_rdata,
  output logic                    act_n,
  output logic                    cs_n,
  output logic [ADDRWIDTH-1:0]    A,
  output logic [BGWIDTH-1:0]      bg,
  output logic [BAWIDTH-1:0]      ba,
  output logic [DQWIDTH-1:0]      dq_o,
  output logic                    dq_oe,
  input  logic [DQWIDTH-1:0]      dq_i,
  input  logic                    stall
);

  localparam int unsigned MaxA  = (TRCD > TCL) ? TRCD : TCL;
  localparam int unsigned MaxB  = (TCWL > TWR) ? TCWL : TWR;
  localparam int unsigned MaxAB = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxT  = (MaxAB > TRP) ? MaxAB : TRP;
  localparam int unsigned CntW  = $clog2(MaxT + BL) + 1;
  localparam int unsigned BeatW = (BL > 1) ? $clog2(BL) : 1;

  // Wait states before a pending command last T-1 cycles so the command lands at T.
  localparam logic [CntW-1:0] LdTrcd = CntW'((TRCD > 1) ? (TRCD - 2) : 0);
  localparam logic [CntW-1:0] LdTwr  = CntW'((TWR > 1) ? (TWR - 2) : 0);
  localparam logic [CntW-1:0] LdTcl  = CntW'(TCL - 1);
  localparam logic [CntW-1:0] LdTcwl = CntW'(TCWL - 1);
  localparam logic [CntW-1:0] LdBl   = CntW'(BL - 1);
  localparam logic [CntW-1:0] LdTrp  = CntW'(TRP - 1);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StAct     = 4'd1;
  localparam logic [3:0] StTrcdW   = 4'd2;
  localparam logic [3:0] StCmd     = 4'd3;
  localparam logic [3:0] StRdW     = 4'd4;
  localparam logic [3:0] StRdBurst = 4'd5;
  localparam logic [3:0] StWrW     = 4'd6;
  localparam logic [3:0] StWrBurst = 4'd7;
  localparam logic [3:0] StTwrW    = 4'd8;
  localparam logic [3:0] StPre     = 4'd9;
  localparam logic [3:0] StTrpW    = 4'd10;

  logic [3:0]             r_state, w_state;
  logic [CntW-1:0]        r_cnt, w_cnt;
  logic [BeatW-1:0]       r_beat, w_beat;
  logic                   w_latch, w_pre_due;

  logic                   r_we;
  logic [BGWIDTH-1:0]     r_bg;
  logic [BAWIDTH-1:0]     r_ba;
  logic [ADDRWIDTH-1:0]   r_row;
  logic [COLWIDTH-1:0]    r_col;
  logic [BL*DQWIDTH-1:0]  r_wdata;
  logic [BL*DQWIDTH-1:0]  r_rbuf, w_rbuf;

  logic                   r_cs_n, w_cs_n;
  logic                   r_act_n, w_act_n;
  logic [ADDRWIDTH-1:0]   r_a, w_a;
  logic [BGWIDTH-1:0]     r_bg_o, w_bg;
  logic [BAWIDTH-1:0]     r_ba_o, w_ba;
  logic [DQWIDTH-1:0]     r_dq_o, w_dq_o;
  logic                   r_dq_oe, w_dq_oe;
  logic                   r_rsp_valid, w_rsp_valid;
  logic [BL*DQWIDTH-1:0]  r_rsp_rdata, w_rsp_rdata;
  logic                   r_req_ready, w_req_ready;

  // Next-state and next-output decode; every output is the registered copy of these.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_beat      = r_beat;
    w_latch     = 1'b0;
    w_pre_due   = 1'b0;
    w_cs_n      = 1'b1;
    w_act_n     = 1'b1;
    w_a         = '0;
    w_bg        = r_bg_o;
    w_ba        = r_ba_o;
    w_dq_o      = '0;
    w_dq_oe     = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_req_ready = 1'b0;
    w_rbuf      = r_rbuf;
    if (r_state == StRdBurst) begin
      w_rbuf[int'(r_beat)*DQWIDTH +: DQWIDTH] = dq_i;
    end

    case (r_state)
      StIdle: begin
        if (req_valid && r_req_ready) begin
          w_latch = 1'b1;
          if (stall) begin
            w_state = StAct;
          end else begin
            w_cs_n  = 1'b0;
            w_act_n = 1'b0;
            w_a     = req_row;
            w_bg    = req_bg;
            w_ba    = req_ba;
            w_state = (TRCD > 1) ? StTrcdW : StCmd;
            w_cnt   = LdTrcd;
          end
        end else begin
          w_req_ready = !stall;
        end
      end
      StAct: begin
        if (!stall) begin
          w_cs_n  = 1'b0;
          w_act_n = 1'b0;
          w_a     = r_row;
          w_bg    = r_bg;
          w_ba    = r_ba;
          w_state = (TRCD > 1) ? StTrcdW : StCmd;
          w_cnt   = LdTrcd;
        end
      end
      StTrcdW: begin
        if (r_cnt == '0) w_state = StCmd;
        else             w_cnt   = r_cnt - CntW'(1);
      end
      StCmd: begin
        if (!stall) begin
          w_cs_n              = 1'b0;
          w_a[COLWIDTH-1:0]   = r_col;
          w_a[10]             = 1'b0;
          w_bg                = r_bg;
          w_ba                = r_ba;
          if (r_we) begin
            w_a[16:14] = 3'b100;
            w_state    = StWrW;
            w_cnt      = LdTcwl;
          end else begin
            w_a[16:14] = 3'b101;
            w_state    = StRdW;
            w_cnt      = LdTcl;
          end
        end
      end
      StRdW: begin
        if (r_cnt == '0) begin
          w_state = StRdBurst;
          w_cnt   = LdBl;
          w_beat  = '0;
        end else begin
          w_cnt = r_cnt - CntW'(1);
        end
      end
      StRdBurst: begin
        // The last beat cycle doubles as the precharge-pending cycle.
        if (r_cnt == '0) begin
          w_pre_due = 1'b1;
        end else begin
          w_cnt  = r_cnt - CntW'(1);
          w_beat = r_beat + BeatW'(1);
        end
      end
      StWrW: begin
        if (r_cnt == '0) begin
          w_state = StWrBurst;
          w_cnt   = LdBl;
          w_dq_oe = 1'b1;
          w_dq_o  = r_wdata[DQWIDTH-1:0];
          w_beat  = BeatW'(1);
        end else begin
          w_cnt = r_cnt - CntW'(1);
        end
      end
      StWrBurst: begin
        if (r_cnt == '0) begin
          w_state = (TWR > 1) ? StTwrW : StPre;
          w_cnt   = LdTwr;
        end else begin
          w_dq_oe = 1'b1;
          w_dq_o  = r_wdata[int'(r_beat)*DQWIDTH +: DQWIDTH];
          w_beat  = r_beat + BeatW'(1);
          w_cnt   = r_cnt - CntW'(1);
        end
      end
      StTwrW: begin
        if (r_cnt == '0) w_state = StPre;
        else             w_cnt   = r_cnt - CntW'(1);
      end
      StPre: begin
        w_pre_due = 1'b1;
      end
      StTrpW: begin
        if (r_cnt == '0) begin
          w_state     = StIdle;
          w_req_ready = !stall;
        end else begin
          w_cnt = r_cnt - CntW'(1);
        end
      end
      default: w_state = StIdle;
    endcase

    // Precharge issue; a read response leaves in the same cycle as its PRE.
    if (w_pre_due) begin
      if (stall) begin
        w_state = StPre;
      end else begin
        w_cs_n     = 1'b0;
        w_a[16:14] = 3'b010;
        w_a[10]    = 1'b0;
        w_bg       = r_bg;
        w_ba       = r_ba;
        if (!r_we) begin
          w_rsp_valid = 1'b1;
          w_rsp_rdata = w_rbuf;
        end
        w_state = StTrpW;
        w_cnt   = LdTrp;
      end
    end
  end

  // State, counters, read buffer and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_rbuf      <= '0;
      r_cs_n      <= 1'b1;
      r_act_n     <= 1'b1;
      r_a         <= '0;
      r_bg_o      <= '0;
      r_ba_o      <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_beat      <= w_beat;
      r_rbuf      <= w_rbuf;
      r_cs_n      <= w_cs_n;
      r_act_n     <= w_act_n;
      r_a         <= w_a;
      r_bg_o      <= w_bg;
      r_ba_o      <= w_ba;
      r_dq_o      <= w_dq_o;
      r_dq_oe     <= w_dq_oe;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_req_ready <= w_req_ready;
    end
  end

  // Request capture on the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_bg    <= '0;
      r_ba    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_we    <= req_we;
      r_bg    <= req_bg;
      r_ba    <= req_ba;
      r_row   <= req_row;
      r_col   <= req_col;
      r_wdata <= req_wdata;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign act_n     = r_act_n;
  assign cs_n      = r_cs_n;
  assign A         = r_a;
  assign bg        = r_bg_o;
  assign ba        = r_ba_o;
  assign dq_o      = r_dq_o;
  assign dq_oe     = r_dq_oe;

endmodule

// File: tb/tb_ddr4_host_cmd_seq.sv
// Directed bench for ddr4_host_cmd_seq with default timings.
// Cycle c is observed #1 after its opening edge; inputs set then apply to cycle c.
module tb_ddr4_host_cmd_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, req_we;
  logic [1:0]   req_bg, req_ba;
  logic [16:0]  req_row;
  logic [9:0]   req_col;
  logic [511:0] req_wdata;
  logic         rsp_valid;
  logic [511:0] rsp_rdata;
  logic         act_n, cs_n;
  logic [16:0]  A;
  logic [1:0]   bg, ba;
  logic [63:0]  dq_o, dq_i;
  logic         dq_oe, stall;

  int total = 0;
  int bad   = 0;
  logic [511:0] exp_rd, exp_st, exp_bb, wd;

  always #5 clk = ~clk;

  ddr4_host_cmd_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_bg    (req_bg),
    .req_ba    (req_ba),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .act_n     (act_n),
    .cs_n      (cs_n),
    .A         (A),
    .bg        (bg),
    .ba        (ba),
    .dq_o      (dq_o),
    .dq_oe     (dq_oe),
    .dq_i      (dq_i),
    .stall     (stall)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    check(tag, req_ready, 1'b1);
  endtask

  // Presents a request when ready; returns in cycle 0 (the ACT cycle).
  task automatic start_req(input logic we, input logic [1:0] b_g, input logic [1:0] b_a,
                           input logic [16:0] row, input logic [9:0] col,
                           input logic [511:0] wdat);
    wait_ready("ready_before_req");
    req_we    = we;
    req_bg    = b_g;
    req_ba    = b_a;
    req_row   = row;
    req_col   = col;
    req_wdata = wdat;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bg = '0; req_ba = '0;
    req_row = '0; req_col = '0; req_wdata = '0; dq_i = '0; stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_rd[k*64 +: 64] = 64'hA0 + 64'(k);
      exp_st[k*64 +: 64] = 64'hB0 + 64'(k);
      exp_bb[k*64 +: 64] = 64'h5500 + 64'(k);
      wd[k*64 +: 64]     = 64'h11 * 64'(k + 1);
    end

    // Reset values
    step(); step();
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_act_n", act_n, 1'b1);
    check("rst_a", A, 17'h0);
    check("rst_bgba", {bg, ba}, 4'h0);
    check("rst_dq", {dq_oe, dq_o}, 65'h0);
    check("rst_rsp", {rsp_valid, rsp_rdata}, 513'h0);
    check("rst_ready", req_ready, 1'b0);
    reset_n = 1'b1;
    step();
    check("ready_after_rst", req_ready, 1'b1);

    // Read: ACT c0, RD c4, beats c10-17, rsp+PRE c18, ready c22
    start_req(1'b0, 2'd1, 2'd2, 17'h1ABC, 10'h3F8, '0);
    check("rd_act", {cs_n, act_n, A}, {2'b00, 17'h1ABC});
    check("rd_act_bank", {bg, ba}, {2'd1, 2'd2});
    for (int c = 1; c <= 22; c++) begin
      step();
      dq_i = (c >= 10 && c <= 17) ? 64'hA0 + 64'(c - 10) : 64'hDEAD;
      if (c == 4) begin
        check("rd_cmd", {cs_n, act_n, A}, {2'b01, 17'h143F8});
        check("rd_cmd_bank", {bg, ba}, {2'd1, 2'd2});
      end else if (c == 18) begin
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_data", rsp_rdata, exp_rd);
        check("rd_pre", {cs_n, act_n, A}, {2'b01, 17'h08000});
      end else begin
        check("rd_des", {cs_n, act_n, rsp_valid}, 3'b110);
      end
      if (c == 21) check("rd_ready_early", req_ready, 1'b0);
      if (c == 22) check("rd_ready", req_ready, 1'b1);
    end
    dq_i = '0;

    // Write: WR c4, dq_oe c9-16, PRE c21, ready c25
    start_req(1'b1, 2'd0, 2'd3, 17'h5, 10'h10, wd);
    check("wr_act", {cs_n, act_n, A}, {2'b00, 17'h5});
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 4)       check("wr_cmd", {cs_n, act_n, A}, {2'b01, 17'h10010});
      else if (c == 21) check("wr_pre", {cs_n, act_n, A}, {2'b01, 17'h08000});
      else              check("wr_des", cs_n, 1'b1);
      if (c >= 9 && c <= 16) check("wr_beat", {dq_oe, dq_o}, {1'b1, 64'h11 * 64'(c - 8)});
      else                   check("wr_oe_low", dq_oe, 1'b0);
      check("wr_no_rsp", rsp_valid, 1'b0);
      if (c == 24) check("wr_ready_early", req_ready, 1'b0);
      if (c == 25) begin
        check("wr_ready", req_ready, 1'b1);
        check("rdata_held", rsp_rdata, exp_rd);
      end
    end

    // Read with stall high c3-c5: RD c7, beats c13-20, rsp+PRE c21
    start_req(1'b0, 2'd0, 2'd1, 17'h22, 10'h8, '0);
    for (int c = 1; c <= 25; c++) begin
      step();
      stall = (c >= 3 && c <= 5);
      dq_i = (c >= 13 && c <= 20) ? 64'hB0 + 64'(c - 13) : 64'hDEAD;
      if (c == 7) begin
        check("st_rd", {cs_n, act_n, A}, {2'b01, 17'h14008});
      end else if (c == 21) begin
        check("st_rsp", {rsp_valid, rsp_rdata}, {1'b1, exp_st});
        check("st_pre", {cs_n, A}, {1'b0, 17'h08000});
      end else begin
        check("st_des", {cs_n, rsp_valid}, 2'b10);
      end
      if (c == 24) check("st_ready_early", req_ready, 1'b0);
      if (c == 25) check("st_ready", req_ready, 1'b1);
    end
    stall = 1'b0;
    dq_i = '0;

    // Back-to-back write then read, req_valid held throughout
    wait_ready("b2b_ready0");
    req_we = 1'b1; req_bg = 2'd2; req_ba = 2'd1; req_row = 17'h1F0F; req_col = 10'h20;
    req_wdata = wd; req_valid = 1'b1;
    step();
    req_we = 1'b0; req_bg = 2'd3; req_ba = 2'd0; req_row = 17'h0777; req_col = 10'h1;
    check("b2b_act1", {cs_n, act_n, A}, {2'b00, 17'h1F0F});
    for (int c = 1; c <= 44; c++) begin
      step();
      if (c == 26) req_valid = 1'b0;
      dq_i = (c >= 36 && c <= 43) ? 64'h5500 + 64'(c - 36) : 64'hDEAD;
      if (c <= 25) check("b2b_no_early_act", act_n, 1'b1);
      if (c == 9)  check("b2b_wr_beat0", {dq_oe, dq_o}, {1'b1, 64'h11});
      if (c == 24) check("b2b_ready_early", req_ready, 1'b0);
      if (c == 25) check("b2b_ready", req_ready, 1'b1);
      // Accepted on the edge after ready is seen, so ACT follows one cycle later.
      if (c == 26) begin
        check("b2b_act2", {cs_n, act_n, A}, {2'b00, 17'h0777});
        check("b2b_act2_bank", {bg, ba}, {2'd3, 2'd0});
      end
      if (c == 30) check("b2b_rd", {cs_n, act_n, A}, {2'b01, 17'h14001});
      if (c >= 26) check("b2b_oe_low", dq_oe, 1'b0);
      if (c == 44) check("b2b_rsp", {rsp_valid, rsp_rdata}, {1'b1, exp_bb});
    end
    dq_i = '0;
    wait_ready("b2b_drain");

    // Reset asserted in c12 of a write burst
    start_req(1'b1, 2'd1, 2'd1, 17'h33, 10'h44, wd);
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 12) begin
        check("rstm_beat3", {dq_oe, dq_o}, {1'b1, 64'h44});
        reset_n = 1'b0;
      end
      if (c == 14) reset_n = 1'b1;
      if (c == 13) begin
        check("rstm_des", {cs_n, act_n, dq_oe, A}, {3'b110, 17'h0});
        check("rstm_out", {rsp_valid, req_ready}, 2'b00);
        check("rstm_rdata", rsp_rdata, 512'h0);
      end
      if (c == 14) check("rstm_ready_held", req_ready, 1'b0);
      if (c == 15) check("rstm_ready", req_ready, 1'b1);
      if (c >= 13) check("rstm_no_cmd", {cs_n, rsp_valid}, 2'b10);
    end

    // Stall in IDLE with a pending request; ready is registered so it lags stall by one
    wait_ready("si_ready0");
    stall = 1'b1;
    step();
    check("si_ready_low", req_ready, 1'b0);
    req_we = 1'b0; req_bg = 2'd0; req_ba = 2'd0; req_row = 17'h1234; req_col = 10'h2;
    req_valid = 1'b1;
    step();
    check("si_hold1", {req_ready, cs_n}, 2'b01);
    step();
    check("si_hold2", {req_ready, cs_n}, 2'b01);
    stall = 1'b0;
    step();
    check("si_ready_back", {req_ready, cs_n}, 2'b11);
    step();
    req_valid = 1'b0;
    check("si_act", {cs_n, act_n, A}, {2'b00, 17'h1234});
    wait_ready("si_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
